// File: rtl/io_out_fifo_pkg.sv
// Shared helpers for the core output-port FIFO.
// Address width derivation keeps a 1-bit address for single-port configurations.
package io_out_fifo_pkg;

   function automatic int addr_width(input int n_ports);
      return (n_ports > 1) ? $clog2(n_ports) : 1;
   endfunction

endpackage

// File: rtl/io_out_fifo_ram.sv
// Entry storage for io_out_fifo: register array, synchronous write, asynchronous read.
// Contents are not reset; the control logic masks the read port while empty.
module io_out_fifo_ram #(
   parameter  int WIDTH = 35,
   parameter  int DEPTH = 8,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [PW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [PW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/io_out_fifo.sv
// Captures core OUT writes into a first-word-fall-through FIFO drained by valid/ready.
// Reports fill level and a sticky overflow flag for a dropped write.
module io_out_fifo
   import io_out_fifo_pkg::*;
#(
   parameter  int NUBITS = 32,
   parameter  int NUIOOU = 8,
   parameter  int FDEPTH = 8,
   localparam int AW     = addr_width(NUIOOU),
   localparam int PW     = $clog2(FDEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              out_en,
   input  logic [AW-1:0]     addr_out,
   input  logic [NUBITS-1:0] data_out,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [AW-1:0]     m_addr,
   output logic [NUBITS-1:0] m_data,
   output logic [PW:0]       level,
   output logic              full,
   output logic              ovf,
   input  logic              ovf_clr
);

   localparam int         EW         = AW + NUBITS;
   localparam logic [PW:0] FULL_LEVEL = FDEPTH[PW:0];

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_level;
   logic          r_ovf;

   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_valid;
   logic          w_drop;
   logic [AW-1:0] w_wr_addr;
   logic [EW-1:0] w_rdata;

   assign w_valid = (r_level != '0);
   assign w_full  = (r_level == FULL_LEVEL);
   assign w_pop   = w_valid & m_ready;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
   assign w_push  = out_en & (~w_full | w_pop);
   assign w_drop  = out_en & w_full & ~w_pop;

   generate
      if (NUIOOU > 1) begin : g_addr
         assign w_wr_addr = addr_out;
      end else begin : g_addr_single
         assign w_wr_addr = '0;
      end
   endgenerate

   io_out_fifo_ram #(
      .WIDTH (EW),
      .DEPTH (FDEPTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata ({w_wr_addr, data_out}),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + (PW+1)'(1);
         end else if (!w_push && w_pop) begin
            r_level <= r_level - (PW+1)'(1);
         end
         // A fresh overflow outranks a clear in the same cycle.
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign m_valid          = w_valid;
   assign {m_addr, m_data} = w_valid ? w_rdata : '0;
   assign level            = r_level;
   assign full             = w_full;
   assign ovf              = r_ovf;

endmodule

// File: tb/tb_io_out_fifo.sv
// Directed self-checking bench for io_out_fifo with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_io_out_fifo;

   localparam int NUBITS = 32;
   localparam int AW     = 3;
   localparam int PW     = 3;

   logic              clk;
   logic              rst;
   logic              out_en;
   logic [AW-1:0]     addr_out;
   logic [NUBITS-1:0] data_out;
   logic              m_valid;
   logic              m_ready;
   logic [AW-1:0]     m_addr;
   logic [NUBITS-1:0] m_data;
   logic [PW:0]       level;
   logic              full;
   logic              ovf;
   logic              ovf_clr;

   int n_checks;
   int n_errors;

   io_out_fifo #(
      .NUBITS (NUBITS),
      .NUIOOU (8),
      .FDEPTH (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .out_en   (out_en),
      .addr_out (addr_out),
      .data_out (data_out),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_addr   (m_addr),
      .m_data   (m_data),
      .level    (level),
      .full     (full),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b0;
      out_en   = 1'b0;
      addr_out = '0;
      data_out = '0;
      m_ready  = 1'b0;
      ovf_clr  = 1'b0;
      #2;
      chk("reset m_valid", 64'(m_valid), 64'd0);
      chk("reset level",   64'(level),   64'd0);
      chk("reset full",    64'(full),    64'd0);
      chk("reset ovf",     64'(ovf),     64'd0);
      chk("reset m_data",  64'(m_data),  64'd0);
      tick();
      rst = 1'b1;
      tick();

      // Ordered capture, then drain
      out_en = 1'b1; addr_out = 3'd3; data_out = 32'h11;
      tick();
      chk("order latency m_valid", 64'(m_valid), 64'd1);
      addr_out = 3'd5; data_out = 32'h22;
      tick();
      addr_out = 3'd7; data_out = 32'h33;
      tick();
      out_en = 1'b0;
      chk("order level 3", 64'(level), 64'd3);
      chk("order head0 addr", 64'(m_addr), 64'd3);
      chk("order head0 data", 64'(m_data), 64'h11);
      m_ready = 1'b1;
      tick();
      chk("order level 2", 64'(level), 64'd2);
      chk("order head1 addr", 64'(m_addr), 64'd5);
      chk("order head1 data", 64'(m_data), 64'h22);
      tick();
      chk("order level 1", 64'(level), 64'd1);
      chk("order head2 addr", 64'(m_addr), 64'd7);
      chk("order head2 data", 64'(m_data), 64'h33);
      tick();
      chk("order level 0", 64'(level), 64'd0);
      chk("order m_valid 0", 64'(m_valid), 64'd0);
      chk("order empty data", 64'(m_data), 64'd0);
      tick();
      chk("ready while empty level", 64'(level), 64'd0);
      m_ready = 1'b0;

      // Fill to full plus one dropped write
      out_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         addr_out = 3'(i);
         data_out = 32'h100 + 32'(i);
         tick();
         if (i == 7) begin
            chk("fill full", 64'(full), 64'd1);
            chk("fill ovf before drop", 64'(ovf), 64'd0);
         end
      end
      out_en = 1'b0;
      chk("fill level 8", 64'(level), 64'd8);
      chk("fill ovf set", 64'(ovf), 64'd1);
      chk("fill head data", 64'(m_data), 64'h100);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("ovf_clr clears", 64'(ovf), 64'd0);

      // Full with simultaneous push and pop
      out_en = 1'b1; addr_out = 3'd2; data_out = 32'hAA; m_ready = 1'b1;
      tick();
      out_en = 1'b0; m_ready = 1'b0;
      chk("full push+pop level", 64'(level), 64'd8);
      chk("full push+pop ovf", 64'(ovf), 64'd0);
      chk("full push+pop head", 64'(m_data), 64'h101);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain data %0d", i), 64'(m_data), (i < 7) ? 64'h101 + 64'(i) : 64'hAA);
         tick();
      end
      m_ready = 1'b0;
      chk("drain empty", 64'(m_valid), 64'd0);

      // Streaming with pointer wrap
      out_en = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         addr_out = 3'(i);
         data_out = 32'(i);
         tick();
         chk($sformatf("stream level %0d", i), 64'(level), 64'd1);
         chk($sformatf("stream data %0d", i), 64'(m_data), 64'(i));
      end
      out_en = 1'b0;
      tick();
      m_ready = 1'b0;
      chk("stream final level", 64'(level), 64'd0);
      chk("stream no drop", 64'(ovf), 64'd0);

      // Overflow in the same cycle as ovf_clr
      out_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         data_out = 32'h200 + 32'(i);
         tick();
      end
      chk("refill full", 64'(full), 64'd1);
      ovf_clr = 1'b1;
      tick();
      out_en = 1'b0; ovf_clr = 1'b0;
      chk("set wins over clr", 64'(ovf), 64'd1);

      // Asynchronous reset mid-stream
      out_en = 1'b1; m_ready = 1'b1;
      #1;
      rst = 1'b0;
      #1;
      chk("async rst m_valid", 64'(m_valid), 64'd0);
      chk("async rst level", 64'(level), 64'd0);
      chk("async rst ovf", 64'(ovf), 64'd0);
      chk("async rst full", 64'(full), 64'd0);
      out_en = 1'b0; m_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      out_en = 1'b1; addr_out = 3'd1; data_out = 32'hBEEF;
      tick();
      out_en = 1'b0;
      chk("post rst m_valid", 64'(m_valid), 64'd1);
      chk("post rst addr", 64'(m_addr), 64'd1);
      chk("post rst data", 64'(m_data), 64'hBEEF);
      chk("post rst level", 64'(level), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "timeout");
   end

endmodule
